// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// Covers opcodes, functs, ALU ops, FSM states, mux selects and the control bundle.
package mc_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_ABS  = 4'd2,
    ALU_PASS = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLT  = 4'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REX,
    S_RWB, S_IEX, S_IWB, S_BEQ, S_JMP, S_ABSX
  } state_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic     pc_write;
    logic     branch;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     ir_write;
    logic     reg_dst;
    logic     mem_to_reg;
    logic     reg_write;
    logic     alu_src_a;
    alusrcb_e alu_src_b;
    pcsrc_e   pc_src;
    alu_op_e  alu_control;
    logic     instr_done;
    logic     illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields and memory ready in, every mux/enable out.
interface mc_control_fsm_if;
  logic [5:0]                     opcode;
  logic [5:0]                     funct;
  logic                           mem_ready;
  logic                           PCWrite;
  logic                           Branch;
  logic                           IorD;
  logic                           MemRead;
  logic                           MemWrite;
  logic                           IRWrite;
  logic                           RegDst;
  logic                           MemToReg;
  logic                           RegWrite;
  logic                           ALUSrcA;
  mc_control_fsm_pkg::alusrcb_e   ALUSrcB;
  mc_control_fsm_pkg::pcsrc_e     PCSrc;
  mc_control_fsm_pkg::alu_op_e    alu_control;
  logic                           instr_done;
  logic                           illegal_op;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, alu_control, instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, alu_control, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_control_fsm_funct_decode.sv
// R-type funct decode: ALU operation plus a legality flag (nop is not an ALU funct).
// Purely combinational; shared by the DECODE legality check and REX.
module mc_control_fsm_funct_decode
  import mc_control_fsm_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_e    alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_PASS;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: Moore decode of the state, with FETCH IR/PC loads
// and memory-wait states gated by mem_ready; all outputs forced low while rst is high.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  ctl
);

  state_e  state;
  state_e  state_nxt;
  logic    is_store;
  ctrl_t   c;
  ctrl_t   c_out;
  alu_op_e fn_alu;
  logic    fn_legal;

  mc_control_fsm_funct_decode u_funct_decode (
    .funct       (ctl.funct),
    .alu_control (fn_alu),
    .legal       (fn_legal)
  );

  // The LW/SW choice is captured in DECODE so MEMADR never looks at the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        is_store <= (ctl.opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    c         = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        if (ctl.mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        case (ctl.opcode)
          OP_LW, OP_SW:      state_nxt = S_MEMADR;
          OP_ADDI, OP_ADDIU: state_nxt = S_IEX;
          OP_BEQ:            state_nxt = S_BEQ;
          OP_J:              state_nxt = S_JMP;
          OP_ABS:            state_nxt = S_ABSX;
          OP_RTYPE: begin
            if (fn_legal) begin
              state_nxt = S_REX;
            end else begin
              c.instr_done = 1'b1;
              c.illegal_op = (ctl.funct != FN_NOP);
              state_nxt    = S_FETCH;
            end
          end
          default: begin
            c.instr_done = 1'b1;
            c.illegal_op = 1'b1;
            state_nxt    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nxt   = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (ctl.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (ctl.mem_ready) begin
          c.instr_done = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_REX: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = fn_alu;
        state_nxt     = S_RWB;
      end
      S_RWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_IEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nxt   = S_IWB;
      end
      S_ABSX: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_ABS;
        state_nxt     = S_IWB;
      end
      S_IWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQ: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.branch      = 1'b1;
        c.pc_src      = PCSRC_ALUOUT;
        c.instr_done  = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JMP: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PCSRC_JUMP;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Gating with rst keeps every strobe low on and after a reset edge.
  assign c_out = rst ? '0 : c;

  assign ctl.PCWrite     = c_out.pc_write;
  assign ctl.Branch      = c_out.branch;
  assign ctl.IorD        = c_out.iord;
  assign ctl.MemRead     = c_out.mem_read;
  assign ctl.MemWrite    = c_out.mem_write;
  assign ctl.IRWrite     = c_out.ir_write;
  assign ctl.RegDst      = c_out.reg_dst;
  assign ctl.MemToReg    = c_out.mem_to_reg;
  assign ctl.RegWrite    = c_out.reg_write;
  assign ctl.ALUSrcA     = c_out.alu_src_a;
  assign ctl.ALUSrcB     = c_out.alu_src_b;
  assign ctl.PCSrc       = c_out.pc_src;
  assign ctl.alu_control = c_out.alu_control;
  assign ctl.instr_done  = c_out.instr_done;
  assign ctl.illegal_op  = c_out.illegal_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: the driver queues one hand-built control vector per cycle,
// a negedge monitor pops and compares it against the full DUT output bundle.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  ctrl_t exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  // mk(pcw, br, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu, done, ill)
  function automatic ctrl_t mk(input logic pcw, br, iord, mr, mw, irw, rd, m2r, rw, sa,
                               input logic [1:0] sb, ps, input logic [3:0] alu,
                               input logic done, ill);
    ctrl_t c;
    c.pc_write = pcw; c.branch = br; c.iord = iord; c.mem_read = mr; c.mem_write = mw;
    c.ir_write = irw; c.reg_dst = rd; c.mem_to_reg = m2r; c.reg_write = rw;
    c.alu_src_a = sa; c.alu_src_b = alusrcb_e'(sb); c.pc_src = pcsrc_e'(ps);
    c.alu_control = alu_op_e'(alu); c.instr_done = done; c.illegal_op = ill;
    return c;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t c;
    c.pc_write = bus.PCWrite; c.branch = bus.Branch; c.iord = bus.IorD;
    c.mem_read = bus.MemRead; c.mem_write = bus.MemWrite; c.ir_write = bus.IRWrite;
    c.reg_dst = bus.RegDst; c.mem_to_reg = bus.MemToReg; c.reg_write = bus.RegWrite;
    c.alu_src_a = bus.ALUSrcA; c.alu_src_b = bus.ALUSrcB; c.pc_src = bus.PCSrc;
    c.alu_control = bus.alu_control; c.instr_done = bus.instr_done;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  // Hand-derived per-state control vectors.
  function automatic ctrl_t v_zero();         return mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_fetch(input logic r); return mk(r,0,0,1,0,r,0,0,0,0,2'b01,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_dec();          return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_dec_nop();      return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd0,1,0); endfunction
  function automatic ctrl_t v_dec_ill();      return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd0,1,1); endfunction
  function automatic ctrl_t v_madr();         return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_mrd();          return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_mwb();          return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic ctrl_t v_mwr(input logic r); return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'd0,r,0); endfunction
  function automatic ctrl_t v_rex(input logic [3:0] a); return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,a,0,0); endfunction
  function automatic ctrl_t v_rwb();          return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic ctrl_t v_iex();          return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'd0,0,0); endfunction
  function automatic ctrl_t v_iwb();          return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'd0,1,0); endfunction
  function automatic ctrl_t v_absx();         return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'd2,0,0); endfunction
  function automatic ctrl_t v_beq();          return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,4'd1,1,0); endfunction
  function automatic ctrl_t v_jmp();          return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,4'd0,1,0); endfunction

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic step(input logic r, input logic rdy, input ctrl_t e, input string nm);
    rst           = r;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    ctrl_t e;
    ctrl_t g;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        g  = sample();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s: got %h required %h", nm, g, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  int rfn[6]  = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h2A};
  int ralu[6] = '{0, 1, 4, 5, 6, 7};

  initial begin : driver
    set_ir(6'h00, 6'h00);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, v_zero(), "reset0");
    step(1, 1, v_zero(), "reset1");

    // ADD, then SUB with a FETCH wait, then the remaining R-types
    for (int i = 0; i < 6; i++) begin
      set_ir(6'h00, 6'(rfn[i]));
      if (i == 1) step(0, 0, v_fetch(0), "r_fetch_wait");
      step(0, 1, v_fetch(1), "r_fetch");
      step(0, 1, v_dec(), "r_decode");
      step(0, 1, v_rex(4'(ralu[i])), "r_rex");
      step(0, 1, v_rwb(), "r_rwb");
    end

    set_ir(6'h23, 6'h15);
    step(0, 1, v_fetch(1), "lw_fetch");
    step(0, 1, v_dec(), "lw_decode");
    step(0, 1, v_madr(), "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, v_mrd(), "lw_memrd_wait");
    step(0, 1, v_mrd(), "lw_memrd_done");
    step(0, 1, v_mwb(), "lw_memwb");

    set_ir(6'h2B, 6'h00);
    step(0, 1, v_fetch(1), "sw_fetch");
    step(0, 1, v_dec(), "sw_decode");
    step(0, 1, v_madr(), "sw_memadr");
    step(0, 0, v_mwr(0), "sw_memwr_wait");
    step(0, 1, v_mwr(1), "sw_memwr_done");

    set_ir(6'h04, 6'h20);
    step(0, 1, v_fetch(1), "beq_fetch");
    step(0, 1, v_dec(), "beq_decode");
    step(0, 1, v_beq(), "beq_exec");

    set_ir(6'h02, 6'h00);
    step(0, 1, v_fetch(1), "j_fetch");
    step(0, 1, v_dec(), "j_decode");
    step(0, 1, v_jmp(), "j_exec");

    set_ir(6'h21, 6'h3F);
    step(0, 1, v_fetch(1), "abs_fetch");
    step(0, 1, v_dec(), "abs_decode");
    step(0, 1, v_absx(), "abs_exec");
    step(0, 1, v_iwb(), "abs_wb");

    set_ir(6'h08, 6'h00);
    step(0, 1, v_fetch(1), "addi_fetch");
    step(0, 1, v_dec(), "addi_decode");
    step(0, 1, v_iex(), "addi_exec");
    step(0, 1, v_iwb(), "addi_wb");

    set_ir(6'h09, 6'h2A);
    step(0, 1, v_fetch(1), "addiu_fetch");
    step(0, 1, v_dec(), "addiu_decode");
    step(0, 1, v_iex(), "addiu_exec");
    step(0, 1, v_iwb(), "addiu_wb");

    set_ir(6'h3F, 6'h20);
    step(0, 1, v_fetch(1), "ill_op_fetch");
    step(0, 1, v_dec_ill(), "ill_op_decode");

    set_ir(6'h00, 6'h3F);
    step(0, 1, v_fetch(1), "ill_fn_fetch");
    step(0, 1, v_dec_ill(), "ill_fn_decode");

    set_ir(6'h00, 6'h00);
    step(0, 1, v_fetch(1), "nop_fetch");
    step(0, 1, v_dec_nop(), "nop_decode");

    // Reset landing in MEMRD of a LW, with mem_ready high during reset
    set_ir(6'h23, 6'h00);
    step(0, 1, v_fetch(1), "lwr_fetch");
    step(0, 1, v_dec(), "lwr_decode");
    step(0, 1, v_madr(), "lwr_memadr");
    step(0, 0, v_mrd(), "lwr_memrd");
    step(1, 1, v_zero(), "lwr_reset0");
    step(1, 1, v_zero(), "lwr_reset1");
    step(0, 0, v_fetch(0), "lwr_post_fetch");
    set_ir(6'h00, 6'h00);
    step(0, 1, v_fetch(1), "lwr_nop_fetch");
    step(0, 1, v_dec_nop(), "lwr_nop_decode");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
